lcd_bcd_scheduler: RTL and testbench
====================================

Name: lcd_bcd_scheduler

Overview:
- Shares one iterative binary-to-BCD engine (shift-add-3) among the three LCD measurement channels: heart rate, RR interval and HRV SDNN.
- Converts a channel only when its input value changes; channels are served round-robin.
- Frame-synchronised output registers hold the BCD values, so ui_display never sees a digit change mid-frame.
- Sits between the ADC/analysis outputs and ui_display, in the sys_clk domain.

Parameters:
- BIN_W, 12, width of each binary input channel.
- DIGITS, 4, number of BCD digits per channel; output width = 4*DIGITS.

Ports:
- sys_clk  input  1  system clock; the only clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- xinlv  input  BIN_W  heart rate, unsigned binary (channel 0).
- rr_current  input  BIN_W  RR interval, unsigned binary (channel 1).
- hrv_sdnn  input  BIN_W  HRV SDNN, unsigned binary (channel 2).
- frame_sync  input  1  one-cycle pulse at start of vertical blank, already in the sys_clk domain.
- xinlv_bcd  output  4*DIGITS  packed BCD of channel 0, MS digit in the top nibble.
- rr_bcd  output  4*DIGITS  packed BCD of channel 1.
- hrv_bcd  output  4*DIGITS  packed BCD of channel 2.
- busy  output  1  high while the engine is in LOAD, SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release):
  - all BCD outputs, staging registers and last_cap[0..2] = 0.
  - busy = 0, state = IDLE, rr_ptr = 0.
  - The value 0 is the correct BCD of a zero input, so no conversion is needed after reset.
- Pending:
  - pend[k] is registered; it is set each cycle that the channel k input != last_cap[k].
  - pend[k] is cleared in the cycle channel k is LOADed. Compare again next cycle.
- Arbitration in IDLE:
  - Among the set pend bits, grant the first channel found from rr_ptr upward, mod 3.
  - On grant, rr_ptr = (grant+1) mod 3.
  - With no pend bits set, stay in IDLE.
- FSM:
  - IDLE -> LOAD when any pend bit is set.
    - LOAD (1 cycle): capture the input into the shift register and into last_cap[grant]; clear BCD accumulator; iteration counter = 0.
  - LOAD -> SHIFT.
    - SHIFT (BIN_W cycles): each cycle, add 3 to every accumulator nibble >= 5, then shift {acc, bin} left by 1. Increment counter.
    - Leave after the BIN_W-th shift.
  - SHIFT -> DONE.
    - DONE (1 cycle): write acc into staging[grant].
  - DONE -> IDLE.
  - Arbitration takes 1 IDLE cycle, so back-to-back conversions cost BIN_W+3 cycles each (15 at default).
- Latency:
  - Input change at edge t -> pend set at t+1 -> LOAD at t+2 (engine idle) -> DONE at t+2+BIN_W+1 -> staging valid the following cycle (t+16 at default).
- Output update: on frame_sync, each output register <= its staging register, using the value present at that edge.
  - If frame_sync and the DONE write coincide, the output takes the old staging value; the new value appears at the next frame_sync.
  - Outputs never change outside frame_sync cycles.
- Change during conversion:
  - The captured value is used for the current conversion.
  - pend re-sets because the input != last_cap, and the channel is reconverted in its next round-robin turn.
  - Intermediate values that never get captured are dropped; this is intended.
- Width: 4095 < 10^4, so DIGITS=4 cannot overflow. The parameter contract is BIN_W <= floor(3.32*DIGITS), enforced by an elaboration-time check.
- Reset mid-conversion: the engine aborts immediately. No partial value reaches staging or the outputs; all state returns to reset values.
- busy = 1 exactly in LOAD/SHIFT/DONE cycles.

Test Plan:
- Reset, all inputs 0, 100 frame_sync pulses -> busy never asserts; all outputs 16'h0000.
- xinlv 0->72 at cycle 10 -> busy 12..25; staging = 16'h0072 at 26; xinlv_bcd = 16'h0072 after the first frame_sync at >= 27, and unchanged before it.
- All three inputs change in one cycle (xinlv=4095, rr_current=800, hrv_sdnn=53), rr_ptr=0 -> conversion order 0,1,2 back-to-back (15 cycles apart); after frame_sync the outputs read 16'h4095, 16'h0800, 16'h0053.
- rr_current 500->600 during the 5th SHIFT cycle of its own conversion -> staging first holds 16'h0500, then 16'h0600 after a second conversion; rr_bcd ends at 16'h0600.
- frame_sync pulsed in the same cycle as DONE for hrv_sdnn=120 -> hrv_bcd keeps its old value; 16'h0120 appears only after the next frame_sync.
- sys_rst_n asserted mid-SHIFT on a xinlv=999 conversion -> outputs 0 and busy 0 immediately; after release the new xinlv is reconverted because last_cap=0.

Source files
------------

// File: rtl/lcd_bcd_scheduler.sv
// rtl/lcd_bcd_scheduler.sv - shared shift-add-3 BCD engine serving three LCD channels round-robin
module lcd_bcd_scheduler #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [BIN_W-1:0]      xinlv,
    input  logic [BIN_W-1:0]      rr_current,
    input  logic [BIN_W-1:0]      hrv_sdnn,
    input  logic                  frame_sync,
    output logic [4*DIGITS-1:0]   xinlv_bcd,
    output logic [4*DIGITS-1:0]   rr_bcd,
    output logic [4*DIGITS-1:0]   hrv_bcd,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // A BIN_W-bit value must fit in DIGITS decimal digits (log2(10) ~ 3.32 bits per digit).
    if (BIN_W * 100 > 332 * DIGITS) begin : g_param_check
        $error("lcd_bcd_scheduler: BIN_W too wide for DIGITS");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         pend_q, pend_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         gsel;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d, adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   chan_in    [3];
    logic [BIN_W-1:0]   last_cap_q [3];
    logic [BCD_W-1:0]   stage_q    [3];
    logic [BCD_W-1:0]   out_q      [3];

    assign chan_in[0] = xinlv;
    assign chan_in[1] = rr_current;
    assign chan_in[2] = hrv_sdnn;

    assign xinlv_bcd = out_q[0];
    assign rr_bcd    = out_q[1];
    assign hrv_bcd   = out_q[2];
    assign busy      = (state_q != IDLE);

    // A channel is pending while its input differs from the last captured value, except in its LOAD cycle.
    always_comb begin
        pend_d = '0;
        for (int k = 0; k < 3; k++) begin
            pend_d[k] = (chan_in[k] != last_cap_q[k]) &&
                        !((state_q == LOAD) && (grant_q == 2'(k)));
        end
    end

    // Round-robin pick: first pending channel at or after rr_ptr, wrapping mod 3.
    always_comb begin
        gsel = 2'd0;
        case (rr_ptr_q)
            2'd1:    gsel = pend_q[1] ? 2'd1 : (pend_q[2] ? 2'd2 : 2'd0);
            2'd2:    gsel = pend_q[2] ? 2'd2 : (pend_q[0] ? 2'd0 : 2'd1);
            default: gsel = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Engine sequencing plus the add-3 / shift datapath.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        adj      = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d  = LOAD;
                    grant_d  = gsel;
                    rr_ptr_d = (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
                end
            end
            LOAD: begin
                bin_d   = chan_in[grant_q];
                acc_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine and arbitration state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            bin_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Per-channel capture history, staging results and frame-synchronised outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int k = 0; k < 3; k++) begin
                last_cap_q[k] <= '0;
                stage_q[k]    <= '0;
                out_q[k]      <= '0;
            end
        end else begin
            if (state_q == LOAD) begin
                last_cap_q[grant_q] <= chan_in[grant_q];
            end
            if (state_q == DONE) begin
                stage_q[grant_q] <= acc_q;
            end
            if (frame_sync) begin
                for (int k = 0; k < 3; k++) begin
                    out_q[k] <= stage_q[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bcd_scheduler.sv
// tb/tb_lcd_bcd_scheduler.sv - scoreboard bench for lcd_bcd_scheduler
module tb_lcd_bcd_scheduler;

    localparam int W = 12;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [W-1:0] xinlv = '0, rr_current = '0, hrv_sdnn = '0;
    logic        frame_sync = 1'b0;
    logic [15:0] xinlv_bcd, rr_bcd, hrv_bcd;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    lcd_bcd_scheduler #(.BIN_W(12), .DIGITS(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .xinlv      (xinlv),
        .rr_current (rr_current),
        .hrv_sdnn   (hrv_sdnn),
        .frame_sync (frame_sync),
        .xinlv_bcd  (xinlv_bcd),
        .rr_bcd     (rr_bcd),
        .hrv_bcd    (hrv_bcd),
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] r;
        logic [15:0] h;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   busy_cycles = 0;

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] res;
        int n;
        n = v;
        for (int i = 0; i < 4; i++) begin
            res[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return res;
    endfunction

    // Expected busy: conversions k-cycles after an input change occupy cycles 2..15, then every 15 cycles.
    function automatic int in_win(int k, int n);
        for (int j = 0; j < n; j++) begin
            if (k >= 2 + 15 * j && k <= 15 + 15 * j) return 1;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 12'd4095;
            default: return W'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(string tag, logic [15:0] x, logic [15:0] r, logic [15:0] h);
        exp_t e;
        e.x = x;
        e.r = r;
        e.h = h;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic frame_pulse(string tag, logic [15:0] x, logic [15:0] r, logic [15:0] h);
        tick();
        push(tag, x, r, h);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic busy_at(string tag, int k, int n);
        @(negedge sys_clk);
        check(tag, int'(busy), in_win(k, n));
    endtask

    // Monitor: compare outputs after every frame_sync edge, and require them to hold otherwise.
    logic        fs_prev = 1'b0;
    logic        rst_prev = 1'b0;
    logic [15:0] px = '0, pr = '0, ph = '0;

    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst_n || rst_prev) begin
        end else if (fs_prev) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_update", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, "_xinlv"}, xinlv_bcd, e.x);
                check({e.tag, "_rr"}, rr_bcd, e.r);
                check({e.tag, "_hrv"}, hrv_bcd, e.h);
            end
        end else begin
            check("hold_between_frames", int'({xinlv_bcd, rr_bcd, hrv_bcd} != {px, pr, ph}), 0);
        end
        px <= xinlv_bcd;
        pr <= rr_bcd;
        ph <= hrv_bcd;
        fs_prev <= frame_sync;
        rst_prev <= !sys_rst_n;
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_xinlv", xinlv_bcd, 0);
        check("rst_rr", rr_bcd, 0);
        check("rst_hrv", hrv_bcd, 0);
        sys_rst_n = 1'b1;

        // All-zero inputs: no conversions, outputs stay zero across frames
        for (int i = 0; i < 100; i++) frame_pulse("t1_zero", 16'h0000, 16'h0000, 16'h0000);
        check("t1_busy_never", busy_cycles, 0);

        // Single channel latency, output held until a frame_sync after staging
        tick();
        xinlv = 12'd72;
        for (int k = 1; k <= 17; k++) begin
            tick();
            frame_sync = 1'b0;
            if (k == 10) begin
                push("t2_early", 16'h0000, 16'h0000, 16'h0000);
                frame_sync = 1'b1;
            end else if (k == 16) begin
                push("t2_done", 16'h0072, 16'h0000, 16'h0000);
                frame_sync = 1'b1;
            end
            busy_at("t2_busy", k, 1);
        end

        // Return to rr_ptr = 0 with zero inputs
        xinlv = '0;
        tick();
        sys_rst_n = 1'b0;
        #1;
        check("t2r_busy", int'(busy), 0);
        check("t2r_xinlv", xinlv_bcd, 0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (3) tick();

        // Simultaneous change on all channels: order 0,1,2, 15 cycles apart
        xinlv = 12'd4095;
        rr_current = 12'd800;
        hrv_sdnn = 12'd53;
        for (int k = 1; k <= 48; k++) begin
            tick();
            frame_sync = 1'b0;
            if (k == 16) begin
                push("t3_ch0", 16'h4095, 16'h0000, 16'h0000);
                frame_sync = 1'b1;
            end else if (k == 31) begin
                push("t3_ch1", 16'h4095, 16'h0800, 16'h0000);
                frame_sync = 1'b1;
            end else if (k == 46) begin
                push("t3_ch2", 16'h4095, 16'h0800, 16'h0053);
                frame_sync = 1'b1;
            end
            busy_at("t3_busy", k, 3);
        end

        // Input changes during the 5th SHIFT of its own conversion
        tick();
        rr_current = 12'd500;
        for (int k = 1; k <= 42; k++) begin
            tick();
            frame_sync = 1'b0;
            if (k == 7) rr_current = 12'd600;
            if (k == 16) begin
                push("t4_first", 16'h4095, 16'h0500, 16'h0053);
                frame_sync = 1'b1;
            end else if (k == 40) begin
                push("t4_second", 16'h4095, 16'h0600, 16'h0053);
                frame_sync = 1'b1;
            end
            busy_at("t4_busy", k, 2);
        end

        // frame_sync coincides with the DONE write
        tick();
        hrv_sdnn = 12'd120;
        for (int k = 1; k <= 22; k++) begin
            tick();
            frame_sync = 1'b0;
            if (k == 15) begin
                push("t5_coincide", 16'h4095, 16'h0600, 16'h0053);
                frame_sync = 1'b1;
            end else if (k == 20) begin
                push("t5_next", 16'h4095, 16'h0600, 16'h0120);
                frame_sync = 1'b1;
            end
            busy_at("t5_busy", k, 1);
        end

        // Reset in the middle of a SHIFT sequence
        tick();
        xinlv = 12'd999;
        for (int k = 1; k <= 5; k++) begin
            tick();
            busy_at("t6_busy", k, 1);
        end
        tick();
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_xinlv", xinlv_bcd, 0);
        check("t6_rr", rr_bcd, 0);
        check("t6_hrv", hrv_bcd, 0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (60) tick();
        frame_pulse("t6_reconv", 16'h0999, 16'h0600, 16'h0120);

        // Randomised bursts of changes, then a settled frame
        for (int it = 0; it < 40; it++) begin
            int nchg;
            nchg = $urandom_range(1, 3);
            for (int c = 0; c < nchg; c++) begin
                if ($urandom_range(0, 1) == 1) xinlv = rand_val();
                if ($urandom_range(0, 1) == 1) rr_current = rand_val();
                if ($urandom_range(0, 1) == 1) hrv_sdnn = rand_val();
                repeat ($urandom_range(1, 20)) tick();
            end
            repeat (70) tick();
            frame_pulse("rnd", to_bcd(int'(xinlv)), to_bcd(int'(rr_current)), to_bcd(int'(hrv_sdnn)));
        end

        repeat (5) tick();
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
